// File: rtl/complement_pkg.sv
// -----------------------------------------------------------------------------
// complement_pkg
// Shared definitions for the operand complement stage:
//   mode_e      - per-operand transform selector (pass / ones / twos / abs)
//   state_e     - controller states (IDLE / RUN)
//   chunkCount  - number of RUN cycles needed for one operand
//   invertFor   - whether the operand bits are inverted for a given mode
//   carryFor    - whether a +1 is injected at the least significant chunk
//   ovfFor      - whether a mode applied to the most-negative value overflows
// -----------------------------------------------------------------------------
package complement_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'b00,
    MODE_ONES = 2'b01,
    MODE_TWOS = 2'b10,
    MODE_ABS  = 2'b11
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic int chunkCount(input int dataW, input int chunkW);
    return dataW / chunkW;
  endfunction

  // Abs only negates operands whose sign bit is set.
  function automatic logic invertFor(input mode_e m, input logic msb);
    return (m == MODE_ONES) || (m == MODE_TWOS) || ((m == MODE_ABS) && msb);
  endfunction

  function automatic logic carryFor(input mode_e m, input logic msb);
    return (m == MODE_TWOS) || ((m == MODE_ABS) && msb);
  endfunction

  // Negating 100...0 wraps back to itself; that is the only overflow case.
  function automatic logic ovfFor(input mode_e m, input logic isMin);
    return ((m == MODE_TWOS) || (m == MODE_ABS)) && isMin;
  endfunction

endpackage

// File: rtl/complement_chunk.sv
// -----------------------------------------------------------------------------
// complement_chunk
// Combinational W-bit slice: o_s = (i_a XOR {W{i_inv}}) + i_ci, with carry-out.
// Ports:
//   i_a   [W-1:0]  operand chunk
//   i_inv          invert every bit of the chunk
//   i_ci           carry into the chunk
//   o_s   [W-1:0]  chunk result
//   o_co           carry out of the chunk
// -----------------------------------------------------------------------------
module complement_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_a,
  input  logic         i_inv,
  input  logic         i_ci,
  output logic [W-1:0] o_s,
  output logic         o_co
);

  logic [W:0] w_sum;

  // One extra bit on the adder catches the carry that ripples into the next chunk.
  assign w_sum = {1'b0, i_a ^ {W{i_inv}}} + {{W{1'b0}}, i_ci};
  assign o_s   = w_sum[W-1:0];
  assign o_co  = w_sum[W];

endmodule

// File: rtl/operand_complement_unit.sv
// -----------------------------------------------------------------------------
// operand_complement_unit
// Captures {first, second, operation} and applies a per-operand transform
// (pass / ones / twos / abs), CHUNK_W bits per cycle with a registered carry.
// Results appear together with a one-cycle done pulse.
// Ports:
//   i_clk                        clock, rising edge
//   i_rst_n                      asynchronous reset, active low
//   i_nr_coded [2*DATA_W+OP_W-1:0] {first, second, operation}, MSB first
//   i_mode     [3:0]             [3:2] first-operand mode, [1:0] second-operand mode
//   i_start                      request, sampled only while idle
//   o_busy                       transform in progress
//   o_first_nr  [DATA_W-1:0]     transformed first operand
//   o_second_nr [DATA_W-1:0]     transformed second operand
//   o_operation [OP_W-1:0]       captured operation code
//   o_ovf       [1:0]            [1] first, [0] second: negation of 100...0
//   o_done                       one-cycle pulse, results valid
// -----------------------------------------------------------------------------
module operand_complement_unit
  import complement_pkg::*;
#(
  parameter int DATA_W  = 4,
  parameter int OP_W    = 4,
  parameter int CHUNK_W = DATA_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [2*DATA_W+OP_W-1:0] i_nr_coded,
  input  logic [3:0]               i_mode,
  input  logic                     i_start,
  output logic                     o_busy,
  output logic [DATA_W-1:0]        o_first_nr,
  output logic [DATA_W-1:0]        o_second_nr,
  output logic [OP_W-1:0]          o_operation,
  output logic [1:0]               o_ovf,
  output logic                     o_done
);

  localparam int N     = chunkCount(DATA_W, CHUNK_W);
  localparam int CNT_W = $clog2(N) + 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(N - 1);
  localparam logic [DATA_W-1:0] MIN_VAL  = {1'b1, {(DATA_W-1){1'b0}}};

  generate
    if ((DATA_W < 2) || (CHUNK_W < 1) || (CHUNK_W > DATA_W) || ((DATA_W % CHUNK_W) != 0)) begin : gBadParams
      $error("operand_complement_unit: CHUNK_W must divide DATA_W and DATA_W must be at least 2");
    end
  endgenerate

  state_e r_state;
  state_e w_stateNext;

  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_shiftA;
  logic [DATA_W-1:0] r_shiftB;
  logic              r_invA;
  logic              r_invB;
  logic              r_carryA;
  logic              r_carryB;
  logic [OP_W-1:0]   r_opHold;
  logic [1:0]        r_ovfHold;

  logic [DATA_W-1:0] r_firstNr;
  logic [DATA_W-1:0] r_secondNr;
  logic [OP_W-1:0]   r_operation;
  logic [1:0]        r_ovf;
  logic              r_done;

  logic [DATA_W-1:0]  w_firstIn;
  logic [DATA_W-1:0]  w_secondIn;
  logic [OP_W-1:0]    w_opIn;
  mode_e              w_modeA;
  mode_e              w_modeB;
  logic [CHUNK_W-1:0] w_sA;
  logic [CHUNK_W-1:0] w_sB;
  logic               w_coA;
  logic               w_coB;
  logic [DATA_W-1:0]  w_nextA;
  logic [DATA_W-1:0]  w_nextB;
  logic               w_capture;
  logic               w_last;

  assign w_firstIn  = i_nr_coded[2*DATA_W+OP_W-1 -: DATA_W];
  assign w_secondIn = i_nr_coded[DATA_W+OP_W-1 -: DATA_W];
  assign w_opIn     = i_nr_coded[OP_W-1:0];
  assign w_modeA    = mode_e'(i_mode[3:2]);
  assign w_modeB    = mode_e'(i_mode[1:0]);

  assign w_capture = (r_state == ST_IDLE) && i_start;
  assign w_last    = (r_state == ST_RUN) && (r_cnt == LAST_CNT);

  complement_chunk #(.W(CHUNK_W)) u_chunkA (
    .i_a   (r_shiftA[CHUNK_W-1:0]),
    .i_inv (r_invA),
    .i_ci  (r_carryA),
    .o_s   (w_sA),
    .o_co  (w_coA)
  );

  complement_chunk #(.W(CHUNK_W)) u_chunkB (
    .i_a   (r_shiftB[CHUNK_W-1:0]),
    .i_inv (r_invB),
    .i_ci  (r_carryB),
    .o_s   (w_sB),
    .o_co  (w_coB)
  );

  // The chunk result enters at the top while the operand drains out of the
  // bottom, so after N cycles the register holds the full result in order.
  generate
    if (N == 1) begin : gSingleChunk
      assign w_nextA = w_sA;
      assign w_nextB = w_sB;
    end else begin : gMultiChunk
      assign w_nextA = {w_sA, r_shiftA[DATA_W-1:CHUNK_W]};
      assign w_nextB = {w_sB, r_shiftB[DATA_W-1:CHUNK_W]};
    end
  endgenerate

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state logic: start is only honoured while idle, and the run ends on
  // the N-th chunk.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      ST_IDLE: if (i_start) w_stateNext = ST_RUN;
      ST_RUN:  if (w_last)  w_stateNext = ST_IDLE;
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    o_busy = (r_state == ST_RUN);
    o_done = r_done;
  end

  // Datapath: capture on start, step one chunk per RUN cycle, and publish the
  // results on the final step. The last chunk's result is taken straight from
  // the shift input so outputs and done line up with the final edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= '0;
      r_shiftA    <= '0;
      r_shiftB    <= '0;
      r_invA      <= 1'b0;
      r_invB      <= 1'b0;
      r_carryA    <= 1'b0;
      r_carryB    <= 1'b0;
      r_opHold    <= '0;
      r_ovfHold   <= '0;
      r_firstNr   <= '0;
      r_secondNr  <= '0;
      r_operation <= '0;
      r_ovf       <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_capture) begin
        r_cnt     <= '0;
        r_shiftA  <= w_firstIn;
        r_shiftB  <= w_secondIn;
        r_invA    <= invertFor(w_modeA, w_firstIn[DATA_W-1]);
        r_invB    <= invertFor(w_modeB, w_secondIn[DATA_W-1]);
        r_carryA  <= carryFor(w_modeA, w_firstIn[DATA_W-1]);
        r_carryB  <= carryFor(w_modeB, w_secondIn[DATA_W-1]);
        r_opHold  <= w_opIn;
        r_ovfHold <= {ovfFor(w_modeA, w_firstIn == MIN_VAL),
                      ovfFor(w_modeB, w_secondIn == MIN_VAL)};
      end else if (r_state == ST_RUN) begin
        r_cnt    <= r_cnt + CNT_W'(1);
        r_shiftA <= w_nextA;
        r_shiftB <= w_nextB;
        r_carryA <= w_coA;
        r_carryB <= w_coB;
        if (w_last) begin
          r_firstNr   <= w_nextA;
          r_secondNr  <= w_nextB;
          r_operation <= r_opHold;
          r_ovf       <= r_ovfHold;
          r_done      <= 1'b1;
        end
      end
    end
  end

  assign o_first_nr  = r_firstNr;
  assign o_second_nr = r_secondNr;
  assign o_operation = r_operation;
  assign o_ovf       = r_ovf;

endmodule
